// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and the register
// command decoder that feeds it.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam int P_N_REQ   = 2;
    localparam int P_MAX_LEN = 4;

    // Byte command codes understood by the register command decoder.
    localparam logic [7:0] P_CMD_NOP = 8'h00;
    localparam logic [7:0] P_CMD_WR  = 8'h01;
    localparam logic [7:0] P_CMD_RD  = 8'h02;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// when searching upward from last+1, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the slot after the previous owner so that owner goes last.
    always_comb begin
        // NOTE: outputs get defaults before the loop so no path infers a latch.
        valid = 1'b0;
        index = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!valid && req[(int'(last) + i) % N_REQ]) begin
                valid = 1'b1;
                index = IDX_W'((int'(last) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ frame
// requesters. A grant is held for a whole frame; bytes are pulled one at a
// time with byte_ack_o and written to the transmitter with tx_wr_o.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = P_N_REQ,
    parameter int MAX_LEN = P_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*LEN_W-1:0] len_i,
    input  logic [N_REQ*8-1:0]     data_i,
    output logic [N_REQ-1:0]       byte_ack_o,
    output logic [N_REQ-1:0]       done_o,
    output logic [N_REQ-1:0]       grant_o,
    output logic                   busy_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_wr_o,
    input  logic                   tx_done_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last;
    logic [LEN_W-1:0] remaining;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [LEN_W-1:0] pick_len;
    logic [LEN_W-1:0] pick_len_clamped;
    logic [7:0]       pick_data;
    logic [7:0]       cur_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_i),
        .last  (last),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign pick_oh          = N_REQ'(1) << pick_idx;
    assign pick_len         = len_i[int'(pick_idx)*LEN_W +: LEN_W];
    assign pick_len_clamped = (pick_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pick_len;
    assign pick_data        = data_i[int'(pick_idx)*8 +: 8];
    assign cur_data         = data_i[int'(idx)*8 +: 8];

    assign busy_o = (state != S_IDLE);

    // Frame FSM with registered strobes, grant and transmit byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register is cleared, so a reset mid-frame simply drops the frame.
            state      <= S_IDLE;
            idx        <= '0;
            last       <= IDX_W'(N_REQ - 1);
            remaining  <= '0;
            grant_o    <= '0;
            byte_ack_o <= '0;
            done_o     <= '0;
            tx_data_o  <= '0;
            tx_wr_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so each branch sees pre-edge state.
            byte_ack_o <= '0;
            done_o     <= '0;
            tx_wr_o    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        if (pick_len != '0) begin
                            idx        <= pick_idx;
                            remaining  <= pick_len_clamped;
                            grant_o    <= pick_oh;
                            tx_data_o  <= pick_data;
                            tx_wr_o    <= 1'b1;
                            byte_ack_o <= pick_oh;
                            state      <= S_SEND;
                        end else begin
                            // Empty frame: acknowledge completion without sending.
                            done_o <= pick_oh;
                            last   <= pick_idx;
                        end
                    end
                end
                S_SEND: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done_i) begin
                        if (remaining <= LEN_W'(1)) begin
                            remaining <= '0;
                            done_o    <= grant_o;
                            last      <= idx;
                            grant_o   <= '0;
                            state     <= S_IDLE;
                        end else begin
                            remaining  <= remaining - LEN_W'(1);
                            tx_data_o  <= cur_data;
                            tx_wr_o    <= 1'b1;
                            byte_ack_o <= grant_o;
                            state      <= S_SEND;
                        end
                    end
                end
                default: begin
                    grant_o <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: stimulus queues expected bytes and frame
// completions, a monitor pops and compares them as the DUT produces them.
module tb_uart_tx_arb;
    import uart_arb_pkg::*;

    localparam int N   = 2;
    localparam int ML  = 4;
    localparam int LW  = $clog2(ML + 1);
    localparam int TXD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [N*LW-1:0] len_i;
    logic [N*8-1:0]  data_i;
    logic [N-1:0]    byte_ack_o;
    logic [N-1:0]    done_o;
    logic [N-1:0]    grant_o;
    logic            busy_o;
    logic [7:0]      tx_data_o;
    logic            tx_wr_o;
    logic            tx_done_i;
    logic            model_done = 1'b0;
    logic            spur_done  = 1'b0;

    assign tx_done_i = model_done | spur_done;

    always #5 clk = ~clk;

    uart_tx_arb #(.N_REQ(N), .MAX_LEN(ML), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .len_i      (len_i),
        .data_i     (data_i),
        .byte_ack_o (byte_ack_o),
        .done_o     (done_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .tx_data_o  (tx_data_o),
        .tx_wr_o    (tx_wr_o),
        .tx_done_i  (tx_done_i)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];

    int checks = 0;
    int errors = 0;

    // Requester model state
    logic [7:0] frame [N][8];
    int         base [N];
    int         ack_cnt [N];

    // Monitor counters
    int tx_wr_cnt   = 0;
    int done_cnt    = 0;
    int done_gap    = 0;
    int gap2_cnt    = 0;
    int cyc         = 0;
    int last_txdone = -100;
    int outstanding = 0;
    int cd          = 0;

    int w0, d0, a0, g0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic set_frame(input int k, input int len, input logic [31:0] bytes);
        for (int i = 0; i < 8; i++) frame[k][i] = bytes[(i % 4)*8 +: 8];
        base[k] = ack_cnt[k];
        len_i[k*LW +: LW] = LW'(len);
    endtask

    task automatic push_byte(input int k, input logic [7:0] b);
        exp_t e;
        e.idx  = k;
        e.data = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy_o || exp_q.size() != 0 || done_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < 200), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_dones(input string name, input int target);
        int n;
        int seen;
        n    = 0;
        seen = 0;
        while (seen < target && n < 300) begin
            @(negedge clk);
            n++;
            if (done_o != '0) seen++;
        end
        req_i = '0;
        check(name, 32'(seen), 32'(target));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tx_wr"},    32'(tx_wr_o),    32'd0);
        check({name, "_grant"},    32'(grant_o),    32'd0);
        check({name, "_busy"},     32'(busy_o),     32'd0);
        check({name, "_done"},     32'(done_o),     32'd0);
        check({name, "_byte_ack"}, 32'(byte_ack_o), 32'd0);
        check({name, "_tx_data"},  32'(tx_data_o),  32'd0);
    endtask

    // Requester data presentation: current byte advances with each byte_ack.
    always_comb begin
        data_i = '0;
        for (int k = 0; k < N; k++) data_i[k*8 +: 8] = frame[k][(ack_cnt[k] - base[k]) & 7];
    end

    // UART TX model: tx_done_i pulses TXD cycles after each write strobe.
    always begin
        @(posedge clk);
        #1;
        model_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) model_done = 1'b1;
        end
        if (tx_wr_o) cd = TXD;
    end

    // Monitor: compares every write strobe and completion against the queues.
    always begin
        exp_t e;
        int   di;
        @(posedge clk);
        #2;
        if (rst) outstanding = 0;
        if (tx_done_i) last_txdone = cyc;
        if (model_done) outstanding = 0;
        if (tx_wr_o) begin
            tx_wr_cnt++;
            if (cyc - last_txdone == 2) gap2_cnt++;
            check("tx_wr_without_done", 32'(outstanding), 32'd0);
            outstanding = 1;
            if (exp_q.size() == 0) begin
                check("unexpected_tx_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data_o), 32'(e.data));
                check("tx_grant", 32'(grant_o), 32'(oh(e.idx)));
            end
        end
        for (int k = 0; k < N; k++) if (byte_ack_o[k]) ack_cnt[k]++;
        if (done_o != '0) begin
            done_cnt++;
            done_gap = cyc - last_txdone;
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                di = done_q.pop_front();
                check("done_owner", 32'(done_o), 32'(oh(di)));
            end
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            ack_cnt[k] = 0;
            base[k]    = 0;
        end
        rst   = 1'b1;
        req_i = '0;
        len_i = '0;
        set_frame(0, 0, 32'h0);
        set_frame(1, 0, 32'h0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: single 3-byte frame from requester 0
        set_frame(0, 3, 32'h00FF5AA5);
        push_byte(0, 8'hA5); push_byte(0, 8'h5A); push_byte(0, 8'hFF);
        done_q.push_back(0);
        w0 = tx_wr_cnt; d0 = done_cnt; a0 = ack_cnt[0];
        req_i = 2'b01;
        @(negedge clk);
        check("t1_latency_tx_wr", 32'(tx_wr_o), 32'd1);
        check("t1_grant", 32'(grant_o), 32'h1);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_byte_ack", 32'(byte_ack_o), 32'h1);
        req_i = 2'b00;
        wait_idle("t1_idle");
        check("t1_tx_wr_count", 32'(tx_wr_cnt - w0), 32'd3);
        check("t1_ack_count", 32'(ack_cnt[0] - a0), 32'd3);
        check("t1_done_count", 32'(done_cnt - d0), 32'd1);
        check("t1_done_after_txdone", 32'(done_gap), 32'd1);
        check("t1_busy_low", 32'(busy_o), 32'd0);

        // 2: contention, both requesting continuously, one byte each
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_frame(0, 1, 32'h11111111);
        set_frame(1, 1, 32'h22222222);
        push_byte(0, 8'h11); push_byte(1, 8'h22); push_byte(0, 8'h11); push_byte(1, 8'h22);
        done_q.push_back(0); done_q.push_back(1); done_q.push_back(0); done_q.push_back(1);
        w0 = tx_wr_cnt; g0 = gap2_cnt;
        req_i = 2'b11;
        wait_dones("t2_four_frames", 4);
        wait_idle("t2_idle");
        check("t2_tx_wr_count", 32'(tx_wr_cnt - w0), 32'd4);
        check("t2_back_to_back_gap", 32'(gap2_cnt - g0), 32'd3);

        // 3a: zero-length frame
        set_frame(0, 0, 32'h0);
        done_q.push_back(0);
        w0 = tx_wr_cnt; d0 = done_cnt;
        req_i = 2'b01;
        @(negedge clk);
        req_i = 2'b00;
        check("t3_zero_done_pulse", 32'(done_o), 32'h1);
        wait_idle("t3_zero_idle");
        check("t3_zero_no_tx_wr", 32'(tx_wr_cnt - w0), 32'd0);
        check("t3_zero_done_count", 32'(done_cnt - d0), 32'd1);

        // 3b: length 7 clamped to 4
        set_frame(1, 7, 32'h04030201);
        push_byte(1, 8'h01); push_byte(1, 8'h02); push_byte(1, 8'h03); push_byte(1, 8'h04);
        done_q.push_back(1);
        w0 = tx_wr_cnt; d0 = done_cnt;
        req_i = 2'b10;
        @(negedge clk);
        req_i = 2'b00;
        wait_idle("t3_clamp_idle");
        check("t3_clamp_tx_wr_count", 32'(tx_wr_cnt - w0), 32'd4);
        check("t3_clamp_done_count", 32'(done_cnt - d0), 32'd1);

        // 4a: spurious tx_done in idle
        w0 = tx_wr_cnt;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check("t4_idle_spur_busy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_idle_spur_no_tx_wr", 32'(tx_wr_cnt - w0), 32'd0);

        // 4b: spurious tx_done in send, request dropped after first byte
        set_frame(0, 3, 32'h00C3C2C1);
        push_byte(0, 8'hC1); push_byte(0, 8'hC2); push_byte(0, 8'hC3);
        done_q.push_back(0);
        w0 = tx_wr_cnt; d0 = done_cnt;
        req_i = 2'b01;
        @(negedge clk);
        spur_done = 1'b1;
        req_i     = 2'b00;
        @(negedge clk);
        spur_done = 1'b0;
        check("t4_send_spur_still_busy", 32'(busy_o), 32'd1);
        wait_idle("t4_idle");
        check("t4_tx_wr_count", 32'(tx_wr_cnt - w0), 32'd3);
        check("t4_done_count", 32'(done_cnt - d0), 32'd1);

        // 5: reset in S_WAIT with two bytes remaining
        set_frame(0, 3, 32'h00D3D2D1);
        push_byte(0, 8'hD1); push_byte(0, 8'hD2);
        w0 = tx_wr_cnt; d0 = done_cnt;
        req_i = 2'b01;
        begin
            int n;
            n = 0;
            while (tx_wr_cnt - w0 < 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t5_reach_second_byte", 32'(n < 100), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        set_frame(0, 1, 32'hE0E0E0E0);
        set_frame(1, 1, 32'hE1E1E1E1);
        req_i = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("t5_after_reset");
        check("t5_no_done_from_abort", 32'(done_cnt - d0), 32'd0);
        push_byte(0, 8'hE0); push_byte(1, 8'hE1);
        done_q.push_back(0); done_q.push_back(1);
        @(negedge clk);
        check("t5_first_grant_req0", 32'(grant_o), 32'h1);
        wait_dones("t5_two_frames", 2);
        wait_idle("t5_idle");
        check("t5_tx_wr_count", 32'(tx_wr_cnt - w0), 32'd4);

        check("final_exp_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
